tdc_uart_tx: RTL and testbench
==============================

# tdc_uart_tx

Readout transmitter for the TDC core: captures each finished measurement word on the TDC `done` strobe, buffers it in a small FIFO and serializes it to the host over an 8N1 UART line. It sits between the TDC measurement output and the board-level TX pin. It decouples the TDC's one-cycle result strobe from the much slower serial link, and flags any result lost to a full buffer.

## Interface

Parameters:
- `DATA_W`, 16: measurement word width. Set equal to the TDC output width.
- `CLKS_PER_BIT`, 868: iClk cycles per UART bit. 868 gives 115200 baud at 100 MHz. Minimum value is 2.
- `FIFO_DEPTH`, 8: number of buffered words. Must be a power of two, minimum 2.

Ports:
- `iClk`, in, 1: single system clock. All logic is on its rising edge.
- `iRst_n`, in, 1: asynchronous, active-low reset.
- `iData`, in, `DATA_W`: measurement word. Connect to the TDC result output.
- `iValid`, in, 1: one-cycle write strobe. Connect to the TDC `done` output.
- `oTx`, out, 1: UART serial output. Idles high.
- `oBusy`, out, 1: high while a frame is on the line or the FIFO is non-empty.
- `oOverflow`, out, 1: sticky flag. Set when a word is dropped.
- `oFifoCount`, out, `$clog2(FIFO_DEPTH)+1`: number of words currently held in the FIFO.

## Operation

Word framing:
- Each word is sent as `NBYTES = (DATA_W+7)/8` bytes, least-significant byte first.
- Bits above `DATA_W` in the top byte are transmitted as 0.
- Each byte is sent as 8N1: one start bit (0), eight data bits LSB first, one stop bit (1).
- Every bit lasts exactly `CLKS_PER_BIT` cycles.

FIFO:
- A write happens on any rising edge where `iValid`=1 and `oFifoCount` < `FIFO_DEPTH`, using the count value from before that edge.
- If `iValid`=1 while the FIFO is full, the word is dropped and `oOverflow` is set. This applies even if a pop occurs on the same edge.
- `oOverflow` stays set until reset.
- A push and a pop on the same edge leave the count unchanged.

TX state machine, states IDLE, START, DATA, STOP:
- IDLE: `oTx`=1. When the FIFO is non-empty, pop the head word into a shift register, set the byte index to 0, and go to START.
- START: drive `oTx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: shift out 8 bits, LSB first, `CLKS_PER_BIT` cycles each, then go to STOP.
- STOP: drive `oTx`=1 for `CLKS_PER_BIT` cycles. Then:
  - if more bytes of the current word remain, increment the byte index and go to START;
  - otherwise, if the FIFO is non-empty, pop the next word and go to START;
  - otherwise go to IDLE.
- There are no idle bits between back-to-back bytes or words.

Register outputs:
- `oTx` is driven from a register, so it never glitches.
- `oBusy` = (state != IDLE) OR (`oFifoCount` != 0).

## Timing

Reset values:
- `oTx`=1, `oBusy`=0, `oOverflow`=0, `oFifoCount`=0, state = IDLE.
- The bit counter, the byte index and the FIFO pointers are all cleared.

Latency:
- Call the edge that captures `iValid` edge N. `oFifoCount` becomes 1 after edge N.
- IDLE pops the word at edge N+1. `oTx` goes low after edge N+1, and `oFifoCount` returns to 0.

Frame length:
- One byte is `10*CLKS_PER_BIT` cycles.
- One word is `NBYTES*10*CLKS_PER_BIT` cycles.

End of transmission:
- `oBusy` falls on the edge that ends the last stop bit, provided the FIFO is empty.

Reset mid-operation:
- Asserting `iRst_n` low forces `oTx`=1 asynchronously and empties the FIFO.
- The partially sent frame is abandoned and is not resumed after reset is released.

Wrap-around:
- The FIFO pointers wrap modulo `FIFO_DEPTH`.
- Full and empty are distinguished by an extra MSB in each pointer.

## Configuration

Macro `TDC_TX_HEADER_EN`:
- Defined: every word is preceded by a sync byte 0xA5, sent with the same 8N1 framing. Word length becomes `(NBYTES+1)*10*CLKS_PER_BIT` cycles, and the state machine sends the header before byte index 0.
- Undefined: no header is sent; only the data bytes go out.

## Test plan

The bench uses `CLKS_PER_BIT`=4, `DATA_W`=16 and `FIFO_DEPTH`=8 unless stated otherwise.
- Single word: `iValid` pulse with `iData`=0x1234 at edge N.
  - `oTx` goes low after edge N+1.
  - Line carries bytes 0x34 then 0x12, 80 cycles total.
  - `oBusy` is high throughout and falls at the end; `oOverflow`=0.
- Header enabled (`TDC_TX_HEADER_EN` defined): same stimulus.
  - Line carries bytes 0xA5, 0x34, 0x12, 120 cycles total.
- Overflow: 10 `iValid` pulses on consecutive edges, words 0x0001 through 0x000A.
  - Words 0x0001 through 0x0009 are transmitted in order; 0x000A is dropped.
  - `oOverflow`=1 from the 10th edge onward; `oFifoCount` peaks at 8.
- Back-to-back: two words, 0xBEEF and 0xCAFE, written on consecutive edges.
  - Line carries bytes 0xEF, 0xBE, 0xFE, 0xCA.
  - Each stop bit is followed directly by the next start bit; total 160 cycles.
- Reset mid-frame: write 0x1234, then pull `iRst_n` low during data bit 3 of the first byte.
  - `oTx`=1 immediately, `oFifoCount`=0, `oBusy`=0.
  - After reset is released, no further transitions appear on `oTx`.
- Narrow word (`DATA_W`=10): write 0x3FF.
  - Line carries bytes 0xFF then 0x03.

Source files
------------

// File: rtl/tdc_uart_tx.sv
`default_nettype none
// ============================================================================
// tdc_uart_tx : FIFO-buffered 8N1 UART readout of TDC result words, LSB byte first.
// Build macro TDC_TX_HEADER_EN prefixes every word with sync byte 0xA5.  Rev 1.0
// ============================================================================
module tdc_uart_tx #(
   parameter int DATA_W       = 16,
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                        iClk,
   input  logic                        iRst_n,
   input  logic [DATA_W-1:0]           iData,
   input  logic                        iValid,
   output logic                        oTx,
   output logic                        oBusy,
   output logic                        oOverflow,
   output logic [$clog2(FIFO_DEPTH):0] oFifoCount
);
   localparam int NBYTES  = (DATA_W + 7) / 8;
   localparam int SHIFT_W = NBYTES * 8;
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW      = (NBYTES > 1) ? $clog2(NBYTES) : 1;
`ifdef TDC_TX_HEADER_EN
   localparam logic HDR_EN = 1'b1;
`else
   localparam logic HDR_EN = 1'b0;
`endif
   localparam logic [7:0]    SYNC_BYTE = 8'hA5;
   localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   logic [DATA_W-1:0]  mem [FIFO_DEPTH];
   logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic               ovf_q, ovf_d;
   state_t             state_q, state_d;
   logic [CW-1:0]      clk_cnt_q, clk_cnt_d;
   logic [2:0]         bit_idx_q, bit_idx_d;
   logic [BW-1:0]      byte_idx_q, byte_idx_d;
   logic               hdr_q, hdr_d;
   logic [7:0]         byte_q, byte_d;
   logic [SHIFT_W-1:0] word_q, word_d;
   logic               tx_q, tx_d;

   logic [AW:0]        w_count;
   logic               w_full, w_empty, w_push, w_pop, w_bit_end;
   logic [SHIFT_W-1:0] w_head;

   // Pointers carry an extra MSB so full and empty differ only in that bit.
   assign w_count = wr_ptr_q - rd_ptr_q;
   assign w_empty = (wr_ptr_q == rd_ptr_q);
   assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign w_push  = iValid && !w_full;

   always_comb begin
      w_head = '0;
      w_head[DATA_W-1:0] = mem[rd_ptr_q[AW-1:0]];
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(w_push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(w_pop);
      ovf_d    = ovf_q | (iValid & w_full);
   end

   always_comb begin
      state_d    = state_q;
      clk_cnt_d  = clk_cnt_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      hdr_d      = hdr_q;
      byte_d     = byte_q;
      word_d     = word_q;
      tx_d       = tx_q;
      w_pop      = 1'b0;
      w_bit_end  = (clk_cnt_q == CLK_LAST);
      if (state_q != S_IDLE) begin
         clk_cnt_d = w_bit_end ? '0 : clk_cnt_q + CW'(1);
      end
      case (state_q)
         S_IDLE: begin
            tx_d  = 1'b1;
            w_pop = !w_empty;
         end
         S_START: begin
            if (w_bit_end) begin
               state_d   = S_DATA;
               bit_idx_d = '0;
               tx_d      = byte_q[0];
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               byte_d = {1'b0, byte_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = byte_q[1];
               end
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               // The header byte occupies a slot before byte index 0, so it does not advance the index.
               if (hdr_q || (byte_idx_q != BYTE_LAST)) begin
                  if (!hdr_q) begin
                     byte_idx_d = byte_idx_q + BW'(1);
                  end
                  hdr_d   = 1'b0;
                  byte_d  = word_q[7:0];
                  word_d  = word_q >> 8;
                  state_d = S_START;
                  tx_d    = 1'b0;
               end else if (!w_empty) begin
                  w_pop = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (w_pop) begin
         state_d    = S_START;
         tx_d       = 1'b0;
         clk_cnt_d  = '0;
         byte_idx_d = '0;
         hdr_d      = HDR_EN;
         byte_d     = HDR_EN ? SYNC_BYTE : w_head[7:0];
         word_d     = HDR_EN ? w_head : (w_head >> 8);
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ovf_q      <= 1'b0;
         state_q    <= S_IDLE;
         clk_cnt_q  <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         hdr_q      <= 1'b0;
         byte_q     <= '0;
         word_q     <= '0;
         tx_q       <= 1'b1;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ovf_q      <= ovf_d;
         state_q    <= state_d;
         clk_cnt_q  <= clk_cnt_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         hdr_q      <= hdr_d;
         byte_q     <= byte_d;
         word_q     <= word_d;
         tx_q       <= tx_d;
      end
   end

   always_ff @(posedge iClk) begin
      if (w_push) begin
         mem[wr_ptr_q[AW-1:0]] <= iData;
      end
   end

   assign oTx        = tx_q;
   assign oBusy      = (state_q != S_IDLE) || (w_count != '0);
   assign oOverflow  = ovf_q;
   assign oFifoCount = w_count;

endmodule
`default_nettype wire

// File: tb/tb_tdc_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_tdc_uart_tx : randomized self-checking bench; a line decoder rebuilds bytes from oTx.
// Rev 1.0
// ============================================================================
module tb_tdc_uart_tx;
   localparam int CPB   = 4;
   localparam int DEPTH = 8;
   localparam int NB    = 2;
`ifdef TDC_TX_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif
   localparam int BYTE_CYC = 10 * CPB;
   localparam int WORD_CYC = (NB + HDR) * BYTE_CYC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] data16 = '0;
   logic        valid16 = 1'b0;
   logic        tx16, busy16, ovf16;
   logic [3:0]  cnt16;
   logic [9:0]  data10 = '0;
   logic        valid10 = 1'b0;
   logic        tx10, busy10, ovf10;
   logic [3:0]  cnt10;
   logic        sel10 = 1'b0;

   wire mon_line = sel10 ? tx10 : tx16;
   wire mon_busy = sel10 ? busy10 : busy16;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   tdc_uart_tx #(.DATA_W(16), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u_dut (
      .iClk(clk), .iRst_n(rst_n), .iData(data16), .iValid(valid16),
      .oTx(tx16), .oBusy(busy16), .oOverflow(ovf16), .oFifoCount(cnt16));

   tdc_uart_tx #(.DATA_W(10), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u_narrow (
      .iClk(clk), .iRst_n(rst_n), .iData(data10), .iValid(valid10),
      .oTx(tx10), .oBusy(busy10), .oOverflow(ovf10), .oFifoCount(cnt10));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Line decoder: written only here; tests read it through snapshot indices.
   logic [7:0] rx_q[$];
   int         start_q[$];
   int         trans = 0;
   int         frame_err = 0;
   logic       prev_line = 1'b1;
   bit         mon_act = 1'b0;
   int         mon_t0 = 0;
   int         mon_off = 0;
   int         mon_j = 0;
   logic [7:0] mon_byte = '0;

   always @(negedge clk) begin
      if (mon_line !== prev_line) trans = trans + 1;
      prev_line = mon_line;
      if (!rst_n) begin
         mon_act = 1'b0;
      end else if (!mon_act) begin
         if (mon_line === 1'b0) begin
            mon_act = 1'b1;
            mon_t0  = cyc;
            start_q.push_back(cyc);
         end
      end else begin
         mon_off = cyc - mon_t0;
         if (mon_off % CPB == CPB / 2) begin
            mon_j = mon_off / CPB;
            if (mon_j == 0) begin
               if (mon_line !== 1'b0) frame_err = frame_err + 1;
            end else if (mon_j <= 8) begin
               mon_byte[mon_j-1] = mon_line;
            end else begin
               if (mon_line !== 1'b1) frame_err = frame_err + 1;
               rx_q.push_back(mon_byte);
               mon_act = 1'b0;
            end
         end
      end
   end

   // Reference model: expected line bytes for a word, derived from the framing rules.
   logic [7:0] exp_q[$];

   function automatic void add_word(input logic [31:0] w, input int dw);
      logic [31:0] m;
      m = w & ((32'd1 << dw) - 32'd1);
      if (HDR != 0) exp_q.push_back(8'hA5);
      for (int b = 0; b < (dw + 7) / 8; b++) exp_q.push_back(8'(m >> (8 * b)));
   endfunction

   task automatic wait_idle(input int bound, output int k);
      k = 0;
      while (k < bound) begin
         @(posedge clk); #1;
         k++;
         if (!mon_busy) break;
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk); #1;
      checks++; if (tx16 !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx16); end
      checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy16); end
      checks++; if (ovf16 !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf16); end
      checks++; if (cnt16 !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt16); end
      checks++; if (tx10 !== 1'b1) begin errors++; $display("FAIL reset_tx10 got %b exp 1", tx10); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      int k, rb, eb;
      exp_q.delete(); add_word(32'h1234, 16);
      rb = rx_q.size(); eb = frame_err;
      data16 = 16'h1234; valid16 = 1'b1;
      @(posedge clk); #1 valid16 = 1'b0;
      checks++; if (cnt16 !== 4'd1) begin errors++; $display("FAIL single_count_n got %0d exp 1", cnt16); end
      checks++; if (tx16 !== 1'b1) begin errors++; $display("FAIL single_tx_n got %b exp 1", tx16); end
      @(posedge clk); #1;
      checks++; if (tx16 !== 1'b0) begin errors++; $display("FAIL single_tx_start got %b exp 0", tx16); end
      checks++; if (cnt16 !== 4'd0) begin errors++; $display("FAIL single_count_pop got %0d exp 0", cnt16); end
      wait_idle(WORD_CYC + 50, k);
      checks++; if (k !== WORD_CYC) begin errors++; $display("FAIL single_length got %0d exp %0d", k, WORD_CYC); end
      checks++; if (rx_q.size() - rb !== exp_q.size()) begin errors++; $display("FAIL single_nbytes got %0d exp %0d", rx_q.size() - rb, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (rb + i >= rx_q.size() || rx_q[rb+i] !== exp_q[i]) begin
            errors++; $display("FAIL single_byte%0d got %0h exp %0h", i, (rb + i < rx_q.size()) ? rx_q[rb+i] : 8'hxx, exp_q[i]);
         end
      end
      checks++; if (ovf16 !== 1'b0) begin errors++; $display("FAIL single_ovf got %b exp 0", ovf16); end
      checks++; if (frame_err !== eb) begin errors++; $display("FAIL single_framing got %0d exp %0d", frame_err - eb, 0); end
      repeat (5) @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int k, rb, sb;
      exp_q.delete(); add_word(32'hBEEF, 16); add_word(32'hCAFE, 16);
      rb = rx_q.size(); sb = start_q.size();
      data16 = 16'hBEEF; valid16 = 1'b1;
      @(posedge clk); #1 data16 = 16'hCAFE;
      @(posedge clk); #1 valid16 = 1'b0;
      wait_idle(2 * WORD_CYC + 50, k);
      checks++; if (k !== 2 * WORD_CYC) begin errors++; $display("FAIL b2b_length got %0d exp %0d", k, 2 * WORD_CYC); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (rb + i >= rx_q.size() || rx_q[rb+i] !== exp_q[i]) begin
            errors++; $display("FAIL b2b_byte%0d got %0h exp %0h", i, (rb + i < rx_q.size()) ? rx_q[rb+i] : 8'hxx, exp_q[i]);
         end
      end
      for (int i = 1; i < exp_q.size(); i++) begin
         checks++;
         if (sb + i >= start_q.size() || start_q[sb+i] - start_q[sb+i-1] !== BYTE_CYC) begin
            errors++; $display("FAIL b2b_gap%0d got %0d exp %0d", i, (sb + i < start_q.size()) ? start_q[sb+i] - start_q[sb+i-1] : -1, BYTE_CYC);
         end
      end
      repeat (5) @(posedge clk); #1;
   endtask

   task automatic test_overflow();
      int k, rb, peak;
      exp_q.delete();
      rb = rx_q.size(); peak = 0;
      for (int w = 1; w <= 10; w++) begin
         data16 = 16'(w); valid16 = 1'b1;
         @(posedge clk); #1;
         if (int'(cnt16) > peak) peak = int'(cnt16);
         if (w <= 9) add_word(32'(w), 16);
         checks++;
         if (ovf16 !== (w == 10)) begin errors++; $display("FAIL ovf_edge%0d got %b exp %b", w, ovf16, (w == 10)); end
      end
      valid16 = 1'b0;
      checks++; if (peak !== DEPTH) begin errors++; $display("FAIL ovf_peak got %0d exp %0d", peak, DEPTH); end
      wait_idle(9 * WORD_CYC + 100, k);
      checks++; if (k >= 9 * WORD_CYC + 100) begin errors++; $display("FAIL ovf_drain got timeout exp idle"); end
      checks++; if (rx_q.size() - rb !== exp_q.size()) begin errors++; $display("FAIL ovf_nbytes got %0d exp %0d", rx_q.size() - rb, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (rb + i >= rx_q.size() || rx_q[rb+i] !== exp_q[i]) begin
            errors++; $display("FAIL ovf_byte%0d got %0h exp %0h", i, (rb + i < rx_q.size()) ? rx_q[rb+i] : 8'hxx, exp_q[i]);
         end
      end
      checks++; if (ovf16 !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf16); end
      apply_reset();
      checks++; if (ovf16 !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b exp 0", ovf16); end
   endtask

   task automatic test_reset_mid();
      int tb0, rb;
      logic [7:0] first;
      first = (HDR != 0) ? 8'hA5 : 8'h34;
      data16 = 16'h1234; valid16 = 1'b1;
      @(posedge clk); #1 data16 = 16'h5678;
      @(posedge clk); #1 valid16 = 1'b0;
      repeat (17) @(posedge clk); #1;
      checks++; if (tx16 !== first[3]) begin errors++; $display("FAIL rstmid_bit3 got %b exp %b", tx16, first[3]); end
      checks++; if (cnt16 !== 4'd1) begin errors++; $display("FAIL rstmid_pending got %0d exp 1", cnt16); end
      rst_n = 1'b0;
      #1;
      checks++; if (tx16 !== 1'b1) begin errors++; $display("FAIL rstmid_tx got %b exp 1", tx16); end
      checks++; if (cnt16 !== 4'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", cnt16); end
      checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy16); end
      repeat (2) @(posedge clk); #1 rst_n = 1'b1;
      tb0 = trans; rb = rx_q.size();
      repeat (200) @(posedge clk); #1;
      checks++; if (trans !== tb0) begin errors++; $display("FAIL rstmid_quiet got %0d exp 0", trans - tb0); end
      checks++; if (rx_q.size() !== rb) begin errors++; $display("FAIL rstmid_rx got %0d exp 0", rx_q.size() - rb); end
   endtask

   task automatic test_random();
      int k, rb, gap;
      logic [15:0] w;
      exp_q.delete();
      rb = rx_q.size();
      for (int n = 0; n < 6; n++) begin
         gap = $urandom_range(0, 30);
         if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
         w = 16'($urandom);
         add_word(32'(w), 16);
         data16 = w; valid16 = 1'b1;
         @(posedge clk); #1 valid16 = 1'b0;
      end
      wait_idle(6 * WORD_CYC + 300, k);
      checks++; if (rx_q.size() - rb !== exp_q.size()) begin errors++; $display("FAIL rand_nbytes got %0d exp %0d", rx_q.size() - rb, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (rb + i >= rx_q.size() || rx_q[rb+i] !== exp_q[i]) begin
            errors++; $display("FAIL rand_byte%0d got %0h exp %0h", i, (rb + i < rx_q.size()) ? rx_q[rb+i] : 8'hxx, exp_q[i]);
         end
      end
      checks++; if (ovf16 !== 1'b0) begin errors++; $display("FAIL rand_ovf got %b exp 0", ovf16); end
      repeat (5) @(posedge clk); #1;
   endtask

   task automatic test_narrow();
      int k, rb, eb;
      logic [9:0] w;
      sel10 = 1'b1;
      exp_q.delete();
      rb = rx_q.size(); eb = frame_err;
      w = 10'($urandom);
      add_word(32'h3FF, 10); add_word(32'(w), 10);
      data10 = 10'h3FF; valid10 = 1'b1;
      @(posedge clk); #1 data10 = w;
      @(posedge clk); #1 valid10 = 1'b0;
      wait_idle(2 * WORD_CYC + 50, k);
      checks++; if (k !== 2 * WORD_CYC) begin errors++; $display("FAIL narrow_length got %0d exp %0d", k, 2 * WORD_CYC); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (rb + i >= rx_q.size() || rx_q[rb+i] !== exp_q[i]) begin
            errors++; $display("FAIL narrow_byte%0d got %0h exp %0h", i, (rb + i < rx_q.size()) ? rx_q[rb+i] : 8'hxx, exp_q[i]);
         end
      end
      checks++; if (frame_err !== eb) begin errors++; $display("FAIL narrow_framing got %0d exp 0", frame_err - eb); end
      repeat (5) @(posedge clk); #1;
      sel10 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_reset_mid();
      test_random();
      test_narrow();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
